boot_loader_ctrl: RTL and testbench
===================================

Name: boot_loader_ctrl

Overview:
- Sequences CPU start-up.
- Holds the CPU in reset and receives a byte-stream program image over a valid/ready handshake.
- Assembles big-endian 32-bit instruction words, writes them into instruction memory, and checks an XOR checksum.
- Releases CPU reset a fixed delay after a good load. Sits between the host byte link, the instruction RAM write port, and the CPU reset input.

Parameters:
ADDR_W, 10, instruction memory word-address width; MAX_WORDS = 2**ADDR_W
RELEASE_DELAY, 5, cycles cpu_reset stays high after a successful load

Ports:
clk_cpu  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
boot_req  in  1  one-cycle request to reload; honoured only in RUN or ERROR
rx_valid  in  1  rx_data is valid
rx_data  in  8  incoming image byte
rx_ready  out  1  controller accepts a byte this cycle
mem_we  out  1  instruction memory write strobe
mem_addr  out  ADDR_W  word address of the write
mem_wdata  out  32  instruction word to write
cpu_reset  out  1  reset to the CPU; high except in RUN
done  out  1  load complete and CPU running
error  out  1  load failed (length overflow or checksum mismatch)
words_loaded  out  ADDR_W+1  number of words written in the current load

Behaviour:
- Image format: LEN_HI, LEN_LO (16-bit word count N, big-endian), 4*N data bytes (first byte goes to bits [31:24]), then one checksum byte. Checksum = XOR of every byte from LEN_HI through the last data byte.
- A byte is accepted on a rising edge with rx_valid && rx_ready. rx_ready = 1 only in LEN_HI, LEN_LO, DATA and CSUM, and 0 while reset is high.
- While reset = 1, all outputs are forced to: rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0, words_loaded=0.
- After reset: state = LEN_HI, running checksum = 0, word index = 0.
- LEN_HI: on accept, latch the high byte -> LEN_LO.
- LEN_LO: on accept, form N.
  - N > MAX_WORDS -> ERROR.
  - N == 0 -> CSUM.
  - Otherwise -> DATA.
- DATA: shift in bytes. On the 4th byte of a word, the next cycle has mem_we=1 for exactly one cycle, with mem_addr = word index and mem_wdata = assembled word. words_loaded increments in that same cycle. After word N-1 is accepted -> CSUM.
  - rx_ready stays 1 during the write cycle, so back-to-back bytes are legal and there are no stalls.
- CSUM: on accept, compare the byte with the running XOR.
  - Equal -> HOLD.
  - Unequal -> ERROR.
- HOLD: cpu_reset=1 for RELEASE_DELAY cycles, counted from the first HOLD cycle, then -> RUN.
- RUN: cpu_reset=0, done=1. boot_req -> LEN_HI: cpu_reset=1 on the next cycle, done=0, words_loaded=0, checksum cleared.
- ERROR: error=1, cpu_reset=1, rx_ready=0; bytes are ignored. boot_req -> LEN_HI with error cleared. Otherwise the state is held until reset.
- boot_req is ignored in LEN_HI, LEN_LO, DATA, CSUM and HOLD.
- rx_valid gaps of any length are tolerated in every receiving state; partial words are held.
- Simultaneous reset and boot_req: reset wins.
- Reset mid-load: state returns to LEN_HI, any partial word is discarded, and words already written are not undone. No mem_we is issued in the cycle after reset is asserted.
- mem_addr and mem_wdata hold their last written values while mem_we=0.

Test Plan:
- Good load (defaults): send 00 02 20 08 00 05 20 09 00 0A 0C back-to-back -> writes addr0=0x20080005 and addr1=0x2009000A, words_loaded=2. cpu_reset falls exactly 5 cycles after the CSUM accept edge, then done=1, error=0.
- Bad checksum: same image with final byte 0D -> both writes occur, then error=1, cpu_reset stays 1, rx_ready=0. A boot_req pulse then returns to LEN_HI with error=0 and rx_ready=1.
- Empty image: 00 00 00 -> no mem_we, HOLD for 5 cycles, then RUN with done=1 and words_loaded=0.
- Overflow with ADDR_W=2: send 00 05 -> error=1 on the cycle after LEN_LO accept. No writes occur; further bytes are not accepted.
- Throttled source: good image with rx_valid low for 3 cycles between every byte -> identical memory contents, and one mem_we per word.
- Reset mid-load and reload: assert reset for 1 cycle after 6 data bytes -> state LEN_HI, words_loaded=0, cpu_reset=1. A full good load then succeeds. A boot_req in RUN raises cpu_reset on the next cycle and drops done.

Source files
------------

// File: rtl/boot_loader_ctrl.sv
// CPU start-up sequencer: holds the CPU in reset, loads a length-prefixed byte image
// into instruction memory as big-endian words, verifies an XOR checksum, then releases the CPU.
module boot_loader_ctrl #(
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned RELEASE_DELAY = 5
) (
    input  logic              clk_cpu,
    input  logic              reset,
    input  logic              boot_req,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned MAX_WORDS = 1 << ADDR_W;
    localparam int unsigned HOLD_W    = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_HOLD,
        S_RUN,
        S_ERROR
    } state_t;

    state_t              state;
    logic [7:0]          len_hi;
    logic [15:0]         len;
    logic [7:0]          csum;
    logic [23:0]         shift;
    logic [1:0]          byte_idx;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                accept;

    assign accept = rx_valid && rx_ready;

    // Sequencer with registered outputs; rx_ready is written alongside each state change
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state        <= S_LEN_HI;
            len_hi       <= 8'h00;
            len          <= 16'h0000;
            csum         <= 8'h00;
            shift        <= 24'h000000;
            byte_idx     <= 2'd0;
            hold_cnt     <= '0;
            rx_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'h0000_0000;
            cpu_reset    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_LEN_HI: begin
                    rx_ready <= 1'b1;
                    if (accept) begin
                        len_hi <= rx_data;
                        csum   <= csum ^ rx_data;
                        state  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    rx_ready <= 1'b1;
                    if (accept) begin
                        len  <= {len_hi, rx_data};
                        csum <= csum ^ rx_data;
                        if (32'({len_hi, rx_data}) > MAX_WORDS) begin
                            state    <= S_ERROR;
                            error    <= 1'b1;
                            rx_ready <= 1'b0;
                        end else if ({len_hi, rx_data} == 16'h0000) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    rx_ready <= 1'b1;
                    if (accept) begin
                        csum     <= csum ^ rx_data;
                        shift    <= {shift[15:0], rx_data};
                        byte_idx <= byte_idx + 2'd1;
                        // Fourth byte completes a word: write it on the following cycle
                        if (byte_idx == 2'd3) begin
                            mem_we       <= 1'b1;
                            mem_addr     <= words_loaded[ADDR_W-1:0];
                            mem_wdata    <= {shift, rx_data};
                            words_loaded <= words_loaded + {{ADDR_W{1'b0}}, 1'b1};
                            if (32'(words_loaded) + 32'd1 == 32'(len)) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    rx_ready <= 1'b1;
                    if (accept) begin
                        rx_ready <= 1'b0;
                        hold_cnt <= '0;
                        if (rx_data == csum) begin
                            state <= S_HOLD;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    rx_ready <= 1'b0;
                    if (hold_cnt == HOLD_W'(RELEASE_DELAY - 1)) begin
                        state     <= S_RUN;
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    rx_ready <= 1'b0;
                    if (boot_req) begin
                        state        <= S_LEN_HI;
                        rx_ready     <= 1'b1;
                        cpu_reset    <= 1'b1;
                        done         <= 1'b0;
                        words_loaded <= '0;
                        csum         <= 8'h00;
                        byte_idx     <= 2'd0;
                    end
                end
                S_ERROR: begin
                    rx_ready <= 1'b0;
                    if (boot_req) begin
                        state        <= S_LEN_HI;
                        rx_ready     <= 1'b1;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        csum         <= 8'h00;
                        byte_idx     <= 2'd0;
                    end
                end
                default: begin
                    state    <= S_LEN_HI;
                    rx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Bench for boot_loader_ctrl: directed and random images checked against an image-level model.
module tb_boot_loader_ctrl;

    localparam int unsigned ADDR_W        = 10;
    localparam int unsigned RELEASE_DELAY = 5;
    localparam int unsigned OVF_ADDR_W    = 2;

    logic              clk_cpu = 1'b0;
    logic              reset, boot_req, rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready, mem_we, cpu_reset, done, error;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   words_loaded;

    logic                  reset2, boot_req2, rx_valid2;
    logic [7:0]            rx_data2;
    logic                  rx_ready2, mem_we2, cpu_reset2, done2, error2;
    logic [OVF_ADDR_W-1:0] mem_addr2;
    logic [31:0]           mem_wdata2;
    logic [OVF_ADDR_W:0]   words_loaded2;

    int checks   = 0;
    int failures = 0;
    int wr2_cnt  = 0;

    logic [31:0] wq[$];
    logic [7:0]  img[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    always #5 clk_cpu = ~clk_cpu;

    boot_loader_ctrl #(.ADDR_W(ADDR_W), .RELEASE_DELAY(RELEASE_DELAY)) u_dut (
        .clk_cpu(clk_cpu), .reset(reset), .boot_req(boot_req),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error), .words_loaded(words_loaded)
    );

    boot_loader_ctrl #(.ADDR_W(OVF_ADDR_W), .RELEASE_DELAY(RELEASE_DELAY)) u_ovf (
        .clk_cpu(clk_cpu), .reset(reset2), .boot_req(boot_req2),
        .rx_valid(rx_valid2), .rx_data(rx_data2), .rx_ready(rx_ready2),
        .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .cpu_reset(cpu_reset2), .done(done2), .error(error2), .words_loaded(words_loaded2)
    );

    // Record every memory write seen on the bus
    always @(negedge clk_cpu) begin
        if (mem_we) begin
            wr_addr_q.push_back(32'(mem_addr));
            wr_data_q.push_back(mem_wdata);
        end
        if (mem_we2) wr2_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Image = length (BE16), words (BE32 each), XOR of all preceding bytes (optionally corrupted)
    function automatic void build_image(input logic [7:0] bad_xor);
        logic [7:0] x;
        int n;
        n = wq.size();
        img.delete();
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
        foreach (wq[i]) for (int s = 3; s >= 0; s--) img.push_back(8'(wq[i] >> (8 * s)));
        x = 8'h00;
        foreach (img[i]) x ^= img[i];
        img.push_back(x ^ bad_xor);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && waited < 200) begin
            @(negedge clk_cpu);
            waited++;
        end
        if (!rx_ready) chk("rx_ready_timeout", 64'(rx_ready), 64'd1);
        @(negedge clk_cpu);
        rx_valid = 1'b0;
    endtask

    task automatic send_byte2(input logic [7:0] b);
        int waited;
        waited    = 0;
        rx_valid2 = 1'b1;
        rx_data2  = b;
        while (!rx_ready2 && waited < 200) begin
            @(negedge clk_cpu);
            waited++;
        end
        if (!rx_ready2) chk("ovf_rx_ready_timeout", 64'(rx_ready2), 64'd1);
        @(negedge clk_cpu);
        rx_valid2 = 1'b0;
    endtask

    task automatic run_load(input int gap, input logic [7:0] bad_xor);
        int n;
        n = wq.size();
        build_image(bad_xor);
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i]);
            if (gap > 0 && i < img.size() - 1) repeat (gap) @(negedge clk_cpu);
        end
        chk("write_count", 64'(wr_addr_q.size()), 64'(n));
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            chk("write_addr", 64'(wr_addr_q[i]), 64'(i));
            chk("write_data", 64'(wr_data_q[i]), 64'(wq[i]));
        end
        chk("words_loaded", 64'(words_loaded), 64'(n));
        if (bad_xor != 8'h00) begin
            chk("err_flag", 64'(error), 64'd1);
            chk("err_cpu_reset", 64'(cpu_reset), 64'd1);
            chk("err_rx_ready", 64'(rx_ready), 64'd0);
            chk("err_done", 64'(done), 64'd0);
            rx_valid = 1'b1;
            rx_data  = 8'h5A;
            repeat (3) begin
                @(negedge clk_cpu);
                chk("err_ignores_bytes", 64'(rx_ready), 64'd0);
            end
            rx_valid = 1'b0;
            chk("err_no_extra_write", 64'(wr_addr_q.size()), 64'(n));
            chk("err_held", 64'(error), 64'd1);
        end else begin
            for (int k = 0; k < RELEASE_DELAY; k++) begin
                chk("hold_cpu_reset", 64'(cpu_reset), 64'd1);
                chk("hold_done", 64'(done), 64'd0);
                @(negedge clk_cpu);
            end
            chk("run_cpu_reset", 64'(cpu_reset), 64'd0);
            chk("run_done", 64'(done), 64'd1);
            chk("run_error", 64'(error), 64'd0);
            chk("run_words_loaded", 64'(words_loaded), 64'(n));
        end
    endtask

    task automatic do_boot_req();
        boot_req = 1'b1;
        @(negedge clk_cpu);
        boot_req = 1'b0;
        chk("reload_cpu_reset", 64'(cpu_reset), 64'd1);
        chk("reload_done", 64'(done), 64'd0);
        chk("reload_error", 64'(error), 64'd0);
        chk("reload_rx_ready", 64'(rx_ready), 64'd1);
        chk("reload_words_loaded", 64'(words_loaded), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_error"}, 64'(error), 64'd0);
        chk({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
    endtask

    initial begin
        reset = 1'b1; boot_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        reset2 = 1'b1; boot_req2 = 1'b0; rx_valid2 = 1'b0; rx_data2 = 8'h00;
        repeat (3) @(negedge clk_cpu);
        check_reset_outputs("por");
        chk("por_mem_addr", 64'(mem_addr), 64'd0);
        chk("por_mem_wdata", 64'(mem_wdata), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk_cpu);

        // boot_req while waiting for the length is ignored
        boot_req = 1'b1;
        @(negedge clk_cpu);
        boot_req = 1'b0;
        chk("idle_boot_req_rx_ready", 64'(rx_ready), 64'd1);
        chk("idle_boot_req_cpu_reset", 64'(cpu_reset), 64'd1);

        // Reference image: 00 02 20 08 00 05 20 09 00 0A 0C
        wq = '{32'h2008_0005, 32'h2009_000A};
        run_load(0, 8'h00);
        do_boot_req();

        // Same image with checksum 0D
        wq = '{32'h2008_0005, 32'h2009_000A};
        run_load(0, 8'h01);
        do_boot_req();

        wq.delete();
        run_load(0, 8'h00);
        do_boot_req();

        // Throttled source
        wq.delete();
        repeat (3) wq.push_back($urandom);
        run_load(3, 8'h00);
        do_boot_req();

        // Reset after six data bytes, then a full reload
        wq.delete();
        repeat (2) wq.push_back($urandom);
        build_image(8'h00);
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int i = 0; i < 8; i++) send_byte(img[i]);
        reset = 1'b1;
        @(negedge clk_cpu);
        check_reset_outputs("midload");
        reset = 1'b0;
        @(negedge clk_cpu);
        chk("midload_no_write_after_reset", 64'(wr_addr_q.size()), 64'd1);
        if (wr_data_q.size() > 0) chk("midload_first_word", 64'(wr_data_q[0]), 64'(wq[0]));
        wq.delete();
        repeat (4) wq.push_back($urandom);
        run_load(1, 8'h00);
        do_boot_req();

        // Random images with random gaps and occasional corrupted checksums
        for (int t = 0; t < 8; t++) begin
            logic [7:0] bx;
            wq.delete();
            repeat ($urandom_range(0, 8)) wq.push_back($urandom);
            bx = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_load(int'($urandom_range(0, 2)), bx);
            do_boot_req();
        end

        // Small instance: N=5 exceeds 4 words
        reset2 = 1'b0;
        @(negedge clk_cpu);
        send_byte2(8'h00);
        send_byte2(8'h05);
        chk("ovf_error", 64'(error2), 64'd1);
        chk("ovf_rx_ready", 64'(rx_ready2), 64'd0);
        rx_valid2 = 1'b1;
        rx_data2  = 8'h00;
        repeat (3) begin
            @(negedge clk_cpu);
            chk("ovf_ignores_bytes", 64'(rx_ready2), 64'd0);
        end
        rx_valid2 = 1'b0;
        chk("ovf_no_write", 64'(wr2_cnt), 64'd0);
        chk("ovf_words_loaded", 64'(words_loaded2), 64'd0);
        chk("ovf_cpu_reset", 64'(cpu_reset2), 64'd1);
        boot_req2 = 1'b1;
        @(negedge clk_cpu);
        boot_req2 = 1'b0;
        chk("ovf_reload_error", 64'(error2), 64'd0);

        // N equal to the memory size is legal
        wq.delete();
        repeat (4) wq.push_back($urandom);
        build_image(8'h00);
        foreach (img[i]) send_byte2(img[i]);
        chk("full_write_count", 64'(wr2_cnt), 64'd4);
        chk("full_words_loaded", 64'(words_loaded2), 64'd4);
        chk("full_error", 64'(error2), 64'd0);
        repeat (RELEASE_DELAY) @(negedge clk_cpu);
        chk("full_done", 64'(done2), 64'd1);
        chk("full_cpu_reset", 64'(cpu_reset2), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
